full_adder: RTL and testbench



---
 rtl/full_adder_pkg.sv | 14 +
 rtl/full_adder_bit.sv | 22 ++
 rtl/full_adder.sv | 70 +++++++
 tb/tb_full_adder.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/full_adder_pkg.sv
// full_adder_pkg: shared constants and types for the full_adder slice.
//   FULL_ADDER_MAX_WIDTH  - largest legal operand width of full_adder.
//   full_adder_result_t   - packed {cout, sum} result at maximum width, for
//                           wider datapaths that chain full_adder instances.
package full_adder_pkg;

    localparam int unsigned FULL_ADDER_MAX_WIDTH = 64;

    typedef struct packed {
        logic                            cout;
        logic [FULL_ADDER_MAX_WIDTH-1:0] sum;
    } full_adder_result_t;

endpackage

// File: rtl/full_adder_bit.sv
// full_adder_bit: single-bit full adder cell, the carry-chain primitive.
// Ports:
//   a, b  - addend bits
//   ci    - carry in
//   s     - sum bit
//   co    - carry out
module full_adder_bit (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    logic p;

    // Propagate term is shared between the sum and the carry.
    assign p  = a ^ b;
    assign s  = p ^ ci;
    assign co = (a & b) | (ci & p);

endmodule

// File: rtl/full_adder.sv
// full_adder: parameterizable ripple-carry adder, {cout, sum} = a + b + cin.
// Parameters:
//   WIDTH  - operand width, 1..64 (default 1)
// Ports:
//   clk    - clock, used only with the output register
//   rst_n  - asynchronous active-low reset, used only with the output register
//   a, b   - addends [WIDTH-1:0]
//   cin    - carry into bit 0
//   sum    - sum bits [WIDTH-1:0]
//   cout   - carry out of bit WIDTH-1
// Configuration:
//   FULL_ADDER_REG_OUT_EN - when defined, {cout, sum} is registered
//                           (1-cycle latency, async reset to 0); otherwise
//                           the outputs are purely combinational.
module full_adder
    import full_adder_pkg::*;
#(
    parameter int unsigned WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    if (WIDTH < 1 || WIDTH > FULL_ADDER_MAX_WIDTH) begin : g_bad_width
        $error("full_adder: WIDTH=%0d outside 1..%0d", WIDTH, FULL_ADDER_MAX_WIDTH);
    end

    // c[i] is the carry into bit i; c[WIDTH] is the final carry out.
    logic [WIDTH:0]   c;
    logic [WIDTH-1:0] s_comb;

    assign c[0] = cin;

    for (genvar i = 0; i < WIDTH; i++) begin : g_chain
        full_adder_bit u_bit (
            .a  (a[i]),
            .b  (b[i]),
            .ci (c[i]),
            .s  (s_comb[i]),
            .co (c[i+1])
        );
    end

`ifdef FULL_ADDER_REG_OUT_EN
    logic [WIDTH:0] result_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result_q <= '0;
        end else begin
            result_q <= {c[WIDTH], s_comb};
        end
    end

    assign {cout, sum} = result_q;
`else
    // Clock and reset have no function in the combinational build.
    logic unused_clk_rst;
    assign unused_clk_rst = clk & rst_n;

    assign sum  = s_comb;
    assign cout = c[WIDTH];
`endif

endmodule

// File: tb/tb_full_adder.sv
// tb_full_adder: directed-table and random check of full_adder at WIDTH 1, 8
// and 16. Follows FULL_ADDER_REG_OUT_EN to select combinational or
// one-cycle-latency checking.
module tb_full_adder;

    logic        clk;
    logic        rst_n;
    logic [15:0] a_in;
    logic [15:0] b_in;
    logic        cin_in;

    logic        s1;
    logic        c1;
    logic [7:0]  s8;
    logic        c8;
    logic [15:0] s16;
    logic        c16;

    int total;
    int bad;

    typedef struct {
        int          w;
        logic [15:0] a;
        logic [15:0] b;
        logic        cin;
        logic [16:0] exp;
        string       name;
    } vec_t;

    vec_t vt[$];

    full_adder #(.WIDTH(1)) u_w1 (
        .clk   (clk),
        .rst_n (rst_n),
        .a     (a_in[0:0]),
        .b     (b_in[0:0]),
        .cin   (cin_in),
        .sum   (s1),
        .cout  (c1)
    );

    full_adder #(.WIDTH(8)) u_w8 (
        .clk   (clk),
        .rst_n (rst_n),
        .a     (a_in[7:0]),
        .b     (b_in[7:0]),
        .cin   (cin_in),
        .sum   (s8),
        .cout  (c8)
    );

    full_adder #(.WIDTH(16)) u_w16 (
        .clk   (clk),
        .rst_n (rst_n),
        .a     (a_in),
        .b     (b_in),
        .cin   (cin_in),
        .sum   (s16),
        .cout  (c16)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [16:0] res(input int w);
        case (w)
            1:       return {15'b0, c1, s1};
            8:       return {8'b0, c8, s8};
            default: return {c16, s16};
        endcase
    endfunction

    task automatic check(input string name, input logic [16:0] got, input logic [16:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", name, got, exp);
        end
    endtask

    // Apply one operand set and wait until the result is observable.
    task automatic step(input logic [15:0] ta, input logic [15:0] tb, input logic tc);
`ifdef FULL_ADDER_REG_OUT_EN
        @(negedge clk);
        a_in = ta; b_in = tb; cin_in = tc;
        @(posedge clk);
        #1;
`else
        a_in = ta; b_in = tb; cin_in = tc;
        #5;
`endif
    endtask

    task automatic addv(input int w, input logic [15:0] ta, input logic [15:0] tb,
                        input logic tc, input logic [16:0] e, input string n);
        vec_t v;
        v.w = w; v.a = ta; v.b = tb; v.cin = tc; v.exp = e; v.name = n;
        vt.push_back(v);
    endtask

    initial begin
        logic [15:0] ra;
        logic [15:0] rb;
        logic        rc;
        logic [16:0] rexp;

        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        a_in  = '0;
        b_in  = '0;
        cin_in = 1'b0;

        // WIDTH=1 exhaustive: {a,b,cin} = 000..111 -> {cout,sum}
        addv(1, 16'h0, 16'h0, 1'b0, 17'h0, "w1_000");
        addv(1, 16'h0, 16'h0, 1'b1, 17'h1, "w1_001");
        addv(1, 16'h0, 16'h1, 1'b0, 17'h1, "w1_010");
        addv(1, 16'h0, 16'h1, 1'b1, 17'h2, "w1_011");
        addv(1, 16'h1, 16'h0, 1'b0, 17'h1, "w1_100");
        addv(1, 16'h1, 16'h0, 1'b1, 17'h2, "w1_101");
        addv(1, 16'h1, 16'h1, 1'b0, 17'h2, "w1_110");
        addv(1, 16'h1, 16'h1, 1'b1, 17'h3, "w1_111");
        // WIDTH=8 ripple corners
        addv(8, 16'h00FF, 16'h0000, 1'b1, 17'h100, "w8_ff_00_c1");
        addv(8, 16'h005A, 16'h00A5, 1'b0, 17'h0FF, "w8_5a_a5_c0");
        addv(8, 16'h005A, 16'h00A5, 1'b1, 17'h100, "w8_5a_a5_c1");
        // WIDTH=16 full ripple and top-bit overflow
        addv(16, 16'hFFFF, 16'h0000, 1'b1, 17'h10000, "w16_ripple");
        addv(16, 16'h8000, 16'h8000, 1'b0, 17'h10000, "w16_msb_ovf");
        addv(16, 16'h1234, 16'h4321, 1'b1, 17'h05556, "w16_mixed");

        // Reset behaviour
`ifdef FULL_ADDER_REG_OUT_EN
        a_in = 16'hFFFF; b_in = 16'hFFFF; cin_in = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("reset_w16_zero", res(16), 17'h0);
        check("reset_w1_zero", res(1), 17'h0);
`else
        a_in = 16'h0003; b_in = 16'h0004; cin_in = 1'b0;
        #5;
        check("reset_ignored_w16", res(16), 17'h00007);
`endif
        @(negedge clk);
        rst_n = 1'b1;

        foreach (vt[i]) begin
            step(vt[i].a, vt[i].b, vt[i].cin);
            check(vt[i].name, res(vt[i].w), vt[i].exp);
        end

`ifdef FULL_ADDER_REG_OUT_EN
        // Outputs change only at the capturing edge.
        step(16'h0, 16'h0, 1'b0);
        check("reg_zero_base", res(1), 17'h0);
        @(negedge clk);
        a_in = 16'h1; b_in = 16'h1; cin_in = 1'b1;
        #1;
        check("reg_hold_before_edge", res(1), 17'h0);
        @(posedge clk);
        #1;
        check("reg_after_edge", res(1), 17'h3);
        // Mid-cycle reset clears immediately and discards the result.
        #2;
        rst_n = 1'b0;
        #1;
        check("reg_async_reset_w1", res(1), 17'h0);
        a_in = 16'h1; b_in = 16'h0; cin_in = 1'b0;
        @(posedge clk);
        #1;
        check("reg_held_in_reset", res(1), 17'h0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("reg_release_no_edge", res(1), 17'h0);
        @(posedge clk);
        #1;
        check("reg_first_capture", res(1), 17'h1);
`endif

        // WIDTH=16 random against a 17-bit reference sum
        for (int unsigned n = 0; n < 10000; n++) begin
            ra = 16'($urandom);
            rb = 16'($urandom);
            rc = 1'($urandom);
            rexp = {1'b0, ra} + {1'b0, rb} + {16'b0, rc};
            step(ra, rb, rc);
            check("w16_random", res(16), rexp);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
